// File: rtl/bus_arbiter_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
// Holds the FSM state encoding, the clog2 helper and the default grant hold limit.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    BUSY = 2'd2
  } state_t;

  localparam int MAX_HOLD_DEF = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/bus_arbiter_mux.sv
// Parameterised slice-select mux: picks slice i_en out of a packed NUM_SLICES*BUS_SIZE bus.
module bus_arbiter_mux #(
  parameter  int BITS_ENABLES = 2,
  parameter  int BUS_SIZE     = 8,
  localparam int NUM_SLICES   = 2**BITS_ENABLES
) (
  input  logic [BITS_ENABLES-1:0]        i_en,
  input  logic [NUM_SLICES*BUS_SIZE-1:0] i_data,
  output logic [BUS_SIZE-1:0]            o_data
);

  logic [NUM_SLICES-1:0][BUS_SIZE-1:0] slices;

  assign slices = i_data;
  assign o_data = slices[i_en];

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one BUS_SIZE-wide bus among NUM_SLICES requesters.
// Grants are held for at most MAX_HOLD cycles under contention, with a 1-cycle GAP between owners.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int BITS_ENABLES = 2,
  parameter int BUS_SIZE     = 8,
  parameter int NUM_SLICES   = 2**BITS_ENABLES,
  parameter int MAX_HOLD     = MAX_HOLD_DEF
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic [NUM_SLICES-1:0]          i_req,
  input  logic [NUM_SLICES-1:0]          i_valid,
  input  logic [NUM_SLICES*BUS_SIZE-1:0] i_data,
  output logic [NUM_SLICES-1:0]          o_gnt,
  output logic [BITS_ENABLES-1:0]        o_sel,
  output logic                           o_busy,
  output logic [BUS_SIZE-1:0]            o_data,
  output logic                           o_valid
);

  localparam int HW = clog2(MAX_HOLD);
  typedef logic [BITS_ENABLES-1:0] idx_t;

  state_t                state_q, state_d;
  idx_t                  sel_d, last_q, last_d, win_idx;
  logic [HW-1:0]         hold_q, hold_d;
  logic [NUM_SLICES-1:0] gnt_d;
  logic [BUS_SIZE-1:0]   mux_data;
  logic                  win_ok, others, hold_max, busy;

  // Scans downwards so the last hit is the nearest index after 'last';
  // k == NUM_SLICES wraps to 'last' itself, the lowest priority.
  function automatic logic [BITS_ENABLES:0] rr_pick(input logic [NUM_SLICES-1:0] req,
                                                    input idx_t last);
    idx_t idx;
    rr_pick = '0;
    for (int k = NUM_SLICES; k >= 1; k--) begin
      idx = last + idx_t'(k);
      if (req[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  assign {win_ok, win_idx} = rr_pick(i_req, last_q);
  assign others   = |(i_req & ~o_gnt);
  assign hold_max = (hold_q == HW'(MAX_HOLD - 1));
  assign busy     = (state_q == BUSY);
  assign o_busy   = busy;

  always_comb begin
    state_d = state_q;
    sel_d   = o_sel;
    last_d  = last_q;
    hold_d  = hold_q;
    gnt_d   = o_gnt;
    case (state_q)
      IDLE, GAP: begin
        if (win_ok) begin
          state_d = BUSY;
          sel_d   = win_idx;
          gnt_d   = NUM_SLICES'(1) << win_idx;
          hold_d  = '0;
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      BUSY: begin
        // Release takes precedence over preemption; both land in the same GAP.
        if (!i_req[o_sel] || (hold_max && others)) begin
          state_d = GAP;
          gnt_d   = '0;
          last_d  = o_sel;
        end else if (!hold_max) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      o_sel   <= '0;
      o_gnt   <= '0;
      last_q  <= idx_t'(NUM_SLICES - 1);
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      o_sel   <= sel_d;
      o_gnt   <= gnt_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  bus_arbiter_mux #(
    .BITS_ENABLES(BITS_ENABLES),
    .BUS_SIZE    (BUS_SIZE)
  ) u_mux (
    .i_en  (o_sel),
    .i_data(i_data),
    .o_data(mux_data)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= busy & i_valid[o_sel];
      if (busy && i_valid[o_sel]) o_data <= mux_data;
    end
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that shares one BUS_SIZE-wide bus among NUM_SLICES requesters and sequences the slice-select mux that drives it. Each requester holds a request line for the length of its transaction. The arbiter issues a one-hot grant and a binary select, and registers the selected slice onto the shared output. It sits between the debug/memory-access requesters and the shared data port, and owns the mux select.

## Interface
- BITS_ENABLES, 2: select width; NUM_SLICES = 2**BITS_ENABLES requesters.
- BUS_SIZE, 8: data width per requester.
- NUM_SLICES, 2**BITS_ENABLES: derived; do not override.
- MAX_HOLD, 16: maximum BUSY cycles per grant while another requester waits; must be ≥ 2.
- i_clock  in  1  single clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_req  in  NUM_SLICES  per-requester request, held high for the whole transaction.
- i_valid  in  NUM_SLICES  per-requester data-valid qualifier.
- i_data  in  NUM_SLICES*BUS_SIZE  packed requester data; slice k at [k*BUS_SIZE +: BUS_SIZE].
- o_gnt  out  NUM_SLICES  registered one-hot grant.
- o_sel  out  BITS_ENABLES  registered binary index of current owner.
- o_busy  out  1  high while in BUSY.
- o_data  out  BUS_SIZE  registered selected data.
- o_valid  out  1  registered: owner's i_valid, sampled while BUSY.

## Operation
- States: IDLE, BUSY, GAP. Reset → IDLE, o_gnt=0, o_sel=0, o_busy=0, o_data=0, o_valid=0, last=NUM_SLICES-1, hold_cnt=0.
- Winner: first asserted i_req scanning indices last+1, last+2, … mod NUM_SLICES. After reset, requester 0 has top priority.
- IDLE: if any i_req, go to BUSY, owner=winner, o_gnt=1<<owner, o_sel=owner, hold_cnt=0. Otherwise stay.
- BUSY, checks in priority order:
  - i_req[owner]=0: go to GAP.
  - hold_cnt==MAX_HOLD-1 and any other i_req high: preempt, go to GAP.
  - Otherwise hold_cnt saturates at MAX_HOLD-1 and increments before that.
- GAP: exactly 1 cycle. o_gnt=0, o_busy=0, last=owner, o_sel keeps the old owner. The next state is evaluated as in IDLE, using the updated last.
- Preempted requester: may keep i_req high and is re-granted in its round-robin turn. It must treat the loss of o_gnt as the end of its grant.
- Datapath, every cycle:
  - o_data ← i_data slice o_sel when in BUSY and i_valid[o_sel]=1; otherwise hold.
  - o_valid ← BUSY & i_valid[o_sel].
- Invariants: o_gnt is one-hot or zero, and is never nonzero outside BUSY. o_busy equals |o_gnt.
- i_req or i_valid of non-owners has no effect on o_data or o_valid.

## Timing
- Request-to-grant latency: i_req rises at edge n in IDLE → o_gnt valid after edge n+1.
- Data latency: o_data/o_valid follow o_sel and i_valid with a 1-cycle register delay.
- Release: owner drops i_req at edge n → o_gnt=0 after n+1 (GAP). The next grant appears after n+2 at the earliest.
- Grant tenure under contention: at most MAX_HOLD cycles, then 1 GAP cycle.
- Simultaneous release and preemption: release wins; same GAP either way.
- Reset asserted mid-transaction: all outputs clear immediately (async). The first grant after deassertion goes to the lowest-index requester.

## Structure
- Shared package: state encoding (IDLE/GAP/BUSY), a clog2 helper, and the MAX_HOLD default.
- One sub-module: the existing parameterised mux block, instantiated with i_en=o_sel and i_data. Its output feeds the o_data register.
- Round-robin winner search is a combinational function in the same file.

## Test plan
- Reset, then i_req=4'b0100 → o_gnt=0100, o_sel=2 one cycle later. Drop i_req → one GAP cycle, then IDLE with o_gnt=0.
- i_req=4'b1111 held, MAX_HOLD=4 → grants rotate 0,1,2,3,0. Each grant lasts 4 cycles, separated by 1-cycle gaps.
- Requester 1 owns the bus and drops i_req while requester 3 is waiting → GAP, then o_gnt=1000, o_sel=3.
- Requester 0 alone, held for 40 cycles with MAX_HOLD=16 → no preemption. hold_cnt saturates and o_gnt stays 0001.
- Owner 2 with i_data slice 2=8'hA5, i_valid=0100 → o_data=A5, o_valid=1 one cycle later. A non-owner toggling i_valid leaves o_valid and o_data unchanged.
- Assert i_reset mid-BUSY → o_gnt, o_valid and o_busy are 0 before the next edge. With i_req=1111 after release, the grant goes to requester 0.
